// File: rtl/unidade_controle_leds.sv
// -----------------------------------------------------------------------------
// unidade_controle_leds
//
// Moore control unit for the LED-display version of the memory game. It drives
// every control input of fluxo_dados and reacts to every status output of it.
//
// A round consists of:
//   1. Display: memory words 0..sequencia are shown on the LEDs, each one lit
//      for one timer period (mostra_on) and then dark for one timer period
//      (mostra_off). avanca_exibicao steps the address counter between LEDs.
//   2. Play: the player repeats the sequence. Each move is registered, compared
//      and either advances the address, advances the round, or ends the game.
//      A timeout while waiting for a move also ends the game.
//   The game is won once the last word of the final round (S=15) matches.
//
// Ports
//   clock, reset            : clock (rising edge), async active-high reset
//   iniciar                 : start request, honoured in inicial and end states
//   fimS                    : sequence counter has reached 15
//   fimLedsOn / fimLedsOff  : LED-on / LED-off timer expired
//   jogadaIgualMemoria      : registered move equals current memory word
//   enderecoIgualSequencia  : address counter equals sequence counter
//   tem_jogada              : one-cycle pulse, a key was pressed
//   timeout                 : registered move-timeout flag from the datapath
//   zeraE / contaE          : address counter clear / increment
//   zeraS / contaS          : sequence counter clear / increment (zeraS also
//                             clears the LED timers in the datapath)
//   zeraR / registraR       : move/timeout register clear / load
//   estado_espera           : enables the move-timeout timer
//   estado_ledsOn/Off       : enables the LED-on / LED-off timers
//   pronto, acertou, errou  : game finished / won / lost
//   db_timeout              : lost because of a timeout
//   db_estado               : current state code (debug display)
// -----------------------------------------------------------------------------
module unidade_controle_leds (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimS,
    input  logic       fimLedsOn,
    input  logic       fimLedsOff,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       tem_jogada,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       estado_espera,
    output logic       estado_ledsOn,
    output logic       estado_ledsOff,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    // State codes are visible on db_estado, so the encoding is fixed.
    // Codes 4'hB and 4'hF are unused and recover to INICIAL.
    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        MOSTRA_ON         = 4'h2,
        MOSTRA_OFF        = 4'h3,
        AVANCA_EXIBICAO   = 4'h4,
        PREPARA_JOGADA    = 4'h5,
        ESPERA            = 4'h6,
        REGISTRA          = 4'h7,
        COMPARACAO        = 4'h8,
        PROXIMA_SEQUENCIA = 4'h9,
        PROXIMO_ENDERECO  = 4'hA,
        FIM_ACERTOU       = 4'hC,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERROU         = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end

            PREPARACAO: estado_d = MOSTRA_ON;

            MOSTRA_ON: begin
                if (fimLedsOn) estado_d = MOSTRA_OFF;
            end

            // After the dark period either the whole sequence has been shown
            // (address caught up with the sequence counter) or we move to the
            // next LED.
            MOSTRA_OFF: begin
                if (fimLedsOff) begin
                    if (enderecoIgualSequencia) estado_d = PREPARA_JOGADA;
                    else                        estado_d = AVANCA_EXIBICAO;
                end
            end

            AVANCA_EXIBICAO: estado_d = MOSTRA_ON;

            PREPARA_JOGADA: estado_d = ESPERA;

            // A key press wins over a timeout raised in the same cycle.
            ESPERA: begin
                if (tem_jogada)   estado_d = REGISTRA;
                else if (timeout) estado_d = FIM_TIMEOUT;
            end

            REGISTRA: estado_d = COMPARACAO;

            // The move register was loaded on the edge entering this state,
            // so jogadaIgualMemoria already reflects the new move here.
            COMPARACAO: begin
                if (!jogadaIgualMemoria)                  estado_d = FIM_ERROU;
                else if (enderecoIgualSequencia && fimS)  estado_d = FIM_ACERTOU;
                else if (enderecoIgualSequencia)          estado_d = PROXIMA_SEQUENCIA;
                else                                      estado_d = PROXIMO_ENDERECO;
            end

            PROXIMA_SEQUENCIA: estado_d = MOSTRA_ON;

            PROXIMO_ENDERECO: estado_d = ESPERA;

            FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU: begin
                if (iniciar) estado_d = PREPARACAO;
            end

            default: estado_d = INICIAL;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from the state register only. Because the state
    // register resets asynchronously, every command drops the moment reset
    // rises.
    // -------------------------------------------------------------------------
    always_comb begin
        zeraE          = 1'b0;
        contaE         = 1'b0;
        zeraS          = 1'b0;
        contaS         = 1'b0;
        zeraR          = 1'b0;
        registraR      = 1'b0;
        estado_espera  = 1'b0;
        estado_ledsOn  = 1'b0;
        estado_ledsOff = 1'b0;
        pronto         = 1'b0;
        acertou        = 1'b0;
        errou          = 1'b0;
        db_timeout     = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraS = 1'b1;
                zeraR = 1'b1;
            end
            MOSTRA_ON:       estado_ledsOn  = 1'b1;
            MOSTRA_OFF:      estado_ledsOff = 1'b1;
            AVANCA_EXIBICAO: contaE         = 1'b1;
            PREPARA_JOGADA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA:          estado_espera  = 1'b1;
            REGISTRA:        registraR      = 1'b1;
            // Next round: grow the sequence and restart the display at word 0.
            PROXIMA_SEQUENCIA: begin
                contaS = 1'b1;
                zeraE  = 1'b1;
            end
            PROXIMO_ENDERECO: contaE = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                errou      = 1'b1;
                db_timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_leds.sv
module tb_unidade_controle_leds;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       fimS;
    logic       fimLedsOn;
    logic       fimLedsOff;
    logic       jogadaIgualMemoria = 1'b1;
    logic       enderecoIgualSequencia;
    logic       tem_jogada = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic       estado_espera, estado_ledsOn, estado_ledsOff;
    logic       pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    unidade_controle_leds dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimS(fimS),
        .fimLedsOn(fimLedsOn), .fimLedsOff(fimLedsOff),
        .jogadaIgualMemoria(jogadaIgualMemoria),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .tem_jogada(tem_jogada), .timeout(timeout),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .estado_espera(estado_espera),
        .estado_ledsOn(estado_ledsOn), .estado_ledsOff(estado_ledsOff),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Output vector, MSB first:
    // zeraE contaE zeraS contaS zeraR registraR espera ledsOn ledsOff pronto acertou errou db_timeout
    logic [12:0] outs;
    assign outs = {zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
                   estado_ledsOn, estado_ledsOff, pronto, acertou, errou, db_timeout};

    localparam logic [12:0] O_NONE = 13'h0000;
    localparam logic [12:0] O_PREP = 13'h1500;
    localparam logic [12:0] O_ON   = 13'h0020;
    localparam logic [12:0] O_OFF  = 13'h0010;
    localparam logic [12:0] O_PJ   = 13'h1100;
    localparam logic [12:0] O_ESP  = 13'h0040;
    localparam logic [12:0] O_REG  = 13'h0080;
    localparam logic [12:0] O_PS   = 13'h1200;
    localparam logic [12:0] O_C    = 13'h000C;
    localparam logic [12:0] O_D    = 13'h000B;
    localparam logic [12:0] O_E    = 13'h000A;

    // Minimal datapath model: 50-cycle LED timers and E/S counters.
    int   cnt_on, cnt_off;
    logic [4:0] e_cnt, s_cnt;
    int   contas_at_15;

    always @(posedge clock) begin
        cnt_on  <= estado_ledsOn  ? cnt_on + 1  : 0;
        cnt_off <= estado_ledsOff ? cnt_off + 1 : 0;
        if (zeraE) e_cnt <= 5'd0;
        else if (contaE) e_cnt <= e_cnt + 5'd1;
        if (zeraS) s_cnt <= 5'd0;
        else if (contaS) s_cnt <= s_cnt + 5'd1;
        if (contaS && s_cnt == 5'd15) contas_at_15 <= contas_at_15 + 1;
    end

    assign fimLedsOn  = estado_ledsOn  && (cnt_on  == 49);
    assign fimLedsOff = estado_ledsOff && (cnt_off == 49);
    assign enderecoIgualSequencia = (e_cnt == s_cnt);
    assign fimS = (s_cnt == 5'd15);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while (db_estado !== target && n < budget) begin
            step();
            n++;
        end
        chk(tag, {28'd0, db_estado}, {28'd0, target});
    endtask

    initial begin
        int n_on, n_disp, n_av, n_cyc;
        logic [3:0] exp_st;
        cnt_on = 0; cnt_off = 0; e_cnt = 0; s_cnt = 0; contas_at_15 = 0;

        // Reset state
        #12;
        chk("reset_state", {28'd0, db_estado}, 32'h0);
        chk("reset_outs", {19'd0, outs}, {19'd0, O_NONE});
        reset = 1'b0;
        step();
        step();
        chk("idle_state", {28'd0, db_estado}, 32'h0);

        // Start and round 0
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("prep_state", {28'd0, db_estado}, 32'h1);
        chk("prep_outs", {19'd0, outs}, {19'd0, O_PREP});
        step();
        chk("on_state", {28'd0, db_estado}, 32'h2);
        chk("on_outs", {19'd0, outs}, {19'd0, O_ON});
        n_on = 0;
        while (db_estado == 4'h2 && n_on < 200) begin
            n_on++;
            step();
        end
        chk("ledson_cycles", n_on, 50);
        chk("off_outs", {19'd0, outs}, {19'd0, O_OFF});
        wait_state(4'h5, 200, "to_prepara");
        chk("pj_outs", {19'd0, outs}, {19'd0, O_PJ});
        step();
        chk("espera_outs", {19'd0, outs}, {19'd0, O_ESP});
        step();
        chk("espera_holds", {28'd0, db_estado}, 32'h6);
        tem_jogada = 1'b1;
        step();
        tem_jogada = 1'b0;
        chk("reg_outs", {19'd0, outs}, {19'd0, O_REG});
        step();
        chk("cmp_state", {28'd0, db_estado}, 32'h8);
        chk("cmp_outs", {19'd0, outs}, {19'd0, O_NONE});
        step();
        chk("ps_state", {28'd0, db_estado}, 32'h9);
        chk("ps_outs", {19'd0, outs}, {19'd0, O_PS});
        step();
        chk("back_on", {28'd0, db_estado}, 32'h2);

        // Asynchronous reset mid-display
        step();
        reset = 1'b1;
        #1;
        chk("async_rst_state", {28'd0, db_estado}, 32'h0);
        chk("async_rst_outs", {19'd0, outs}, {19'd0, O_NONE});
        step();
        reset = 1'b0;
        chk("rst_hold", {28'd0, db_estado}, 32'h0);

        // Wrong move
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        wait_state(4'h6, 300, "wrong_to_espera");
        tem_jogada = 1'b1;
        jogadaIgualMemoria = 1'b0;
        step();
        tem_jogada = 1'b0;
        step();
        step();
        chk("errou_state", {28'd0, db_estado}, 32'hE);
        chk("errou_outs", {19'd0, outs}, {19'd0, O_E});
        jogadaIgualMemoria = 1'b1;
        tem_jogada = 1'b1;
        timeout = 1'b1;
        step();
        tem_jogada = 1'b0;
        timeout = 1'b0;
        chk("errou_ignores", {28'd0, db_estado}, 32'hE);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("restart_from_E", {28'd0, db_estado}, 32'h1);

        // Timeout
        wait_state(4'h6, 300, "to_to_espera");
        timeout = 1'b1;
        step();
        timeout = 1'b0;
        chk("timeout_state", {28'd0, db_estado}, 32'hD);
        chk("timeout_outs", {19'd0, outs}, {19'd0, O_D});
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("restart_from_D", {28'd0, db_estado}, 32'h1);
        wait_state(4'h6, 300, "prio_to_espera");
        timeout = 1'b1;
        tem_jogada = 1'b1;
        step();
        timeout = 1'b0;
        tem_jogada = 1'b0;
        chk("jogada_priority", {28'd0, db_estado}, 32'h7);

        // Full game: 16 correct rounds
        reset = 1'b1;
        step();
        reset = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        for (int n = 0; n < 16; n++) begin
            n_disp = 0; n_on = 0; n_av = 0;
            while (db_estado != 4'h5 && n_disp < 3000) begin
                if (estado_ledsOn) n_on++;
                if (db_estado == 4'h4) n_av++;
                n_disp++;
                step();
            end
            if (n == 2) begin
                chk("r2_display_cycles", n_disp, 302);
                chk("r2_ledson_cycles", n_on, 150);
                chk("r2_avanca_cycles", n_av, 2);
            end
            for (int m = 0; m <= n; m++) begin
                n_cyc = 0;
                while (db_estado != 4'h6 && n_cyc < 10) begin
                    step();
                    n_cyc++;
                end
                tem_jogada = 1'b1;
                step();
                tem_jogada = 1'b0;
                step();
                step();
                if (m < n)       exp_st = 4'hA;
                else if (n < 15) exp_st = 4'h9;
                else             exp_st = 4'hC;
                if (db_estado !== exp_st) chk("game_move_state", {28'd0, db_estado}, {28'd0, exp_st});
            end
            if (n < 15) step();
        end
        chk("win_state", {28'd0, db_estado}, 32'hC);
        chk("win_outs", {19'd0, outs}, {19'd0, O_C});
        chk("no_contaS_at_15", contas_at_15, 0);
        step();
        chk("win_holds", {28'd0, db_estado}, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_leds.md
# unidade_controle_leds

Moore control unit that drives `fluxo_dados` for the LED-display version of the memory game. Each round it displays the stored sequence on `leds` (memory word `0..sequencia`, each lit then dark for one timer period). It then collects the player's moves with timeout, compares them, and advances rounds up to 16. It sits directly upstream of `fluxo_dados`: every control input of the datapath is an output here, and every status output of the datapath is an input here.

## Interface
Parameters: none. State encoding is fixed by `db_estado`.

- `clock` in 1 — system clock, rising edge
- `reset` in 1 — asynchronous, active-high; forces state `inicial`
- `iniciar` in 1 — start request, level-sampled
- `fimS` in 1 — sequence counter at 15
- `fimLedsOn` in 1 — LED-on timer done
- `fimLedsOff` in 1 — LED-off timer done
- `jogadaIgualMemoria` in 1 — registered move equals memory word
- `enderecoIgualSequencia` in 1 — address counter equals sequence counter
- `tem_jogada` in 1 — one-cycle pulse: a key was pressed
- `timeout` in 1 — registered timeout flag from datapath
- `zeraE`, `contaE` out 1 — address counter clear / increment
- `zeraS`, `contaS` out 1 — sequence counter clear / increment (`zeraS` also clears the LED timers)
- `zeraR`, `registraR` out 1 — move/timeout register clear / load
- `estado_espera`, `estado_ledsOn`, `estado_ledsOff` out 1 — phase flags to datapath timers
- `pronto` out 1 — game finished
- `acertou` out 1 — won
- `errou` out 1 — lost (wrong move or timeout)
- `db_timeout` out 1 — lost by timeout
- `db_estado` out 4 — current state code

## Operation
- All outputs are decoded from the state register only. Each output is 1 only in the states listed; it is 0 everywhere else.
- State codes (hex) and transitions, one per clock edge:
  - `inicial` 0: `iniciar` → `preparacao`, else stay.
  - `preparacao` 1: `zeraE`, `zeraS`, `zeraR`. Goes to `mostra_on`.
  - `mostra_on` 2: `estado_ledsOn`. `fimLedsOn` → `mostra_off`.
  - `mostra_off` 3: `estado_ledsOff`. On `fimLedsOff`:
    - `enderecoIgualSequencia` → `prepara_jogada`;
    - otherwise → `avanca_exibicao`.
  - `avanca_exibicao` 4: `contaE`. Goes to `mostra_on`.
  - `prepara_jogada` 5: `zeraE`, `zeraR`. Goes to `espera`.
  - `espera` 6: `estado_espera`.
    - `tem_jogada` → `registra`;
    - else `timeout` → `fim_timeout`;
    - `tem_jogada` has priority when both are high.
  - `registra` 7: `registraR`. Goes to `comparacao`.
  - `comparacao` 8: no outputs. Priority order:
    - `!jogadaIgualMemoria` → `fim_errou`;
    - else `enderecoIgualSequencia && fimS` → `fim_acertou`;
    - else `enderecoIgualSequencia` → `proxima_sequencia`;
    - else → `proximo_endereco`.
  - `proxima_sequencia` 9: `contaS`, `zeraE`. Goes to `mostra_on`.
  - `proximo_endereco` A: `contaE`. Goes to `espera`.
  - `fim_acertou` C: `pronto`, `acertou`.
  - `fim_timeout` D: `pronto`, `errou`, `db_timeout`.
  - `fim_errou` E: `pronto`, `errou`.
  - From C, D and E: `iniciar` → `preparacao`, else stay.
- Unused codes B and F go to `inicial` on the next edge with all outputs 0.
- `tem_jogada` and `timeout` are ignored outside `espera`. `iniciar` is ignored outside states 0, C, D and E.

## Timing
- Reset value: state `inicial`, `db_estado`=0, every output 0. Reset mid-game aborts immediately, asynchronously; no datapath command is issued during reset.
- Start latency: `iniciar` high at edge k → `preparacao` during cycle k..k+1 → `mostra_on` from edge k+1.
- With datapath timers M=50, `mostra_on` and `mostra_off` each last 50 cycles. `avanca_exibicao` adds 1 cycle per non-final LED.
- Display of round n (sequencia=n): 100(n+1)+n cycles, from entry to `mostra_on` until entry to `prepara_jogada`.
- Per correct non-final move: `espera` → `registra` → `comparacao` → `proximo_endereco`, 3 cycles after the `tem_jogada` edge.
- `comparacao` reads the register loaded in `registra`, so it sees the new move. `jogadaIgualMemoria` is valid one cycle after `registraR`.
- Round wrap: `proxima_sequencia` increments S and clears E in the same cycle.
- Last round is S=15: a correct move at E=15 ends in `fim_acertou`, and S never wraps.

## Test plan
- Reset during `mostra_on` (`db_estado`=2) → `db_estado`=0 and all outputs 0 within the same cycle, before the next edge.
- `iniciar` pulse with memory word 0 = 0001; then `tem_jogada` with `jogadaIgualMemoria`=1, `enderecoIgualSequencia`=1, `fimS`=0 → sequence 0,1,2,3,5,6,7,8,9,2. `estado_ledsOn` is high exactly 50 cycles per LED.
- Round 2 display (S=2) → exactly three `mostra_on`/`mostra_off` pairs and two `avanca_exibicao` cycles (302 cycles) before state 5.
- Wrong move in `comparacao` (`jogadaIgualMemoria`=0) → state E, `pronto`=1, `errou`=1, `acertou`=0. `iniciar` then → state 1.
- `timeout`=1 with no `tem_jogada` in `espera` → state D, `db_timeout`=1. `timeout` and `tem_jogada` together → state 7.
- Full game: 16 correct rounds, `fimS`=1 at the final `comparacao` → state C, `acertou`=1, and `contaS` is never asserted at S=15.
